// File: rtl/tmu2_unpack.sv
// tmu2_unpack -- wide-to-narrow pipeline down-converter for the TMU2 datapath.
//
// Accepts one wide word (width * 2**log2count bits) per upstream stb/ack
// handshake and replays it downstream as 2**log2count narrow words, lowest
// slice first, sustaining one narrow word per cycle with no bubbles between
// consecutive wide words.
//
// Ports:
//   sys_clk     system clock, all state on the rising edge
//   sys_rst_n   asynchronous active-low reset
//   busy        high while any slice of a wide word is still pending
//   pipe_stb_i  upstream strobe, dat_i valid
//   pipe_ack_o  upstream acknowledge
//   dat_i       wide word; slice k is dat_i[k*width +: width]
//   pipe_stb_o  downstream strobe, dat_o valid
//   pipe_ack_i  downstream acknowledge
//   dat_o       current narrow word
//   last_o      dat_o is the final slice of its wide word (qualified by pipe_stb_o)
module tmu2_unpack #(
   parameter int unsigned width     = 16,
   parameter int unsigned log2count = 2
) (
   input  logic                                sys_clk,
   input  logic                                sys_rst_n,
   output logic                                busy,

   input  logic                                pipe_stb_i,
   output logic                                pipe_ack_o,
   input  logic [width*(1 << log2count)-1:0]   dat_i,

   output logic                                pipe_stb_o,
   input  logic                                pipe_ack_i,
   output logic [width-1:0]                    dat_o,
   output logic                                last_o
);

   localparam int unsigned count = 1 << log2count;
   localparam logic [log2count-1:0] last_index = '1;

   logic [width*count-1:0] hold;
   logic [log2count-1:0]   index;
   logic                   valid;
   logic                   inc;
   logic                   dec;

   assign pipe_stb_o = valid;
   assign busy       = valid;
   assign dat_o      = hold[index*width +: width];
   assign last_o     = (index == last_index);

   // Combinational path from pipe_ack_i: the next wide word is accepted on
   // the same edge that consumes the final slice, so there is no idle cycle.
   assign pipe_ack_o = ~valid | (last_o & pipe_ack_i);

   assign inc = pipe_stb_i & pipe_ack_o;
   assign dec = pipe_stb_o & pipe_ack_i;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold  <= '0;
         index <= '0;
         valid <= 1'b0;
      end else if (inc) begin
         // Covers both an idle load and a last-slice consume with a new load.
         hold  <= dat_i;
         index <= '0;
         valid <= 1'b1;
      end else if (dec && !last_o) begin
         index <= index + 1'b1;
      end else if (dec && last_o) begin
         valid <= 1'b0;
         index <= '0;
      end
   end

endmodule

// File: tb/tb_tmu2_unpack.sv
// tb_tmu2_unpack -- self-checking bench for tmu2_unpack (width=16, N=4).
//
// A lockstep driver applies upstream words and a per-cycle downstream ack
// plan; accepted words push their expected slices onto a scoreboard that is
// compared against dat_o/last_o every cycle, together with stb/busy/ack.
module tb_tmu2_unpack;

   typedef struct packed {
      logic [63:0]      word;
      logic [3:0][15:0] exp;
   } vec_t;

   typedef struct packed {
      logic [15:0] d;
      logic        last;
   } slot_t;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        busy;
   logic        pipe_stb_i;
   logic        pipe_ack_o;
   logic [63:0] dat_i;
   logic        pipe_stb_o;
   logic        pipe_ack_i;
   logic [15:0] dat_o;
   logic        last_o;

   int unsigned errors = 0;
   int unsigned checks = 0;

   vec_t  src_q[$];
   slot_t exp_q[$];
   logic  plan_q[$];
   vec_t  tbl[5];

   tmu2_unpack #(.width(16), .log2count(2)) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .busy       (busy),
      .pipe_stb_i (pipe_stb_i),
      .pipe_ack_o (pipe_ack_o),
      .dat_i      (dat_i),
      .pipe_stb_o (pipe_stb_o),
      .pipe_ack_i (pipe_ack_i),
      .dat_o      (dat_o),
      .last_o     (last_o)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mkv(input logic [63:0] w, input logic [15:0] e3,
                                input logic [15:0] e2, input logic [15:0] e1,
                                input logic [15:0] e0);
      vec_t v;
      v.word = w;
      v.exp  = {e3, e2, e1, e0};
      return v;
   endfunction

   // One clock cycle: drive inputs after the edge, check at the falling edge.
   task automatic cycle();
      logic exp_ack;
      vec_t v;
      @(posedge sys_clk);
      #1;
      pipe_stb_i = (src_q.size() != 0);
      if (src_q.size() != 0) dat_i = src_q[0].word;
      pipe_ack_i = (plan_q.size() != 0) ? plan_q.pop_front() : 1'b1;
      @(negedge sys_clk);
      exp_ack = 1'b1;
      if (exp_q.size() != 0) exp_ack = exp_q[0].last & pipe_ack_i;
      chk("stb_o", pipe_stb_o, exp_q.size() != 0);
      chk("busy", busy, exp_q.size() != 0);
      chk("ack_o", pipe_ack_o, exp_ack);
      if (exp_q.size() != 0) begin
         chk("dat_o", dat_o, exp_q[0].d);
         chk("last_o", last_o, exp_q[0].last);
         if (pipe_ack_i) void'(exp_q.pop_front());
      end
      if (pipe_stb_i && exp_ack) begin
         v = src_q.pop_front();
         for (int k = 0; k < 4; k++) exp_q.push_back('{d: v.exp[k], last: (k == 3)});
      end
   endtask

   task automatic drain(input int unsigned budget);
      int unsigned n = 0;
      do begin
         cycle();
         n++;
      end while ((src_q.size() != 0 || exp_q.size() != 0 || plan_q.size() != 0) && n < budget);
      if (src_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL drain_timeout: pending src=%0d exp=%0d after %0d cycles",
                  src_q.size(), exp_q.size(), n);
         src_q.delete();
         exp_q.delete();
      end
      plan_q.delete();
      // One idle cycle confirms the block returned to idle.
      cycle();
   endtask

   initial begin
      tbl[0] = mkv(64'h4444_3333_2222_1111, 16'h4444, 16'h3333, 16'h2222, 16'h1111);
      tbl[1] = mkv(64'h0000_0000_0000_0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      tbl[2] = mkv(64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      tbl[3] = mkv(64'hDEAD_BEEF_0123_4567, 16'hDEAD, 16'hBEEF, 16'h0123, 16'h4567);
      tbl[4] = mkv(64'h8000_0001_7FFE_A55A, 16'h8000, 16'h0001, 16'h7FFE, 16'hA55A);

      sys_rst_n  = 1'b0;
      pipe_stb_i = 1'b0;
      pipe_ack_i = 1'b0;
      dat_i      = '0;
      #3;
      chk("rst_stb_o", pipe_stb_o, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack_o", pipe_ack_o, 1'b1);
      chk("rst_dat_o", dat_o, 16'h0000);
      chk("rst_last_o", last_o, 1'b0);
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;

      // Table: single words with downstream always ready.
      for (int i = 0; i < 5; i++) begin
         src_q.push_back(tbl[i]);
         drain(20);
      end

      // Back-to-back: two words, strobe and ack always high.
      src_q.push_back(mkv(64'hA3A3_A2A2_A1A1_A0A0, 16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0));
      src_q.push_back(mkv(64'hB3B3_B2B2_B1B1_B0B0, 16'hB3B3, 16'hB2B2, 16'hB1B1, 16'hB0B0));
      drain(30);

      // Stall three cycles while slice 1 is presented.
      src_q.push_back(mkv(64'h5D5D_5C5C_5B5B_5A5A, 16'h5D5D, 16'h5C5C, 16'h5B5B, 16'h5A5A));
      plan_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      drain(30);

      // Stall on the last slice with the next word already waiting.
      src_q.push_back(mkv(64'hC3C3_C2C2_C1C1_C0C0, 16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0));
      src_q.push_back(mkv(64'hD3D3_D2D2_D1D1_D0D0, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0));
      plan_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      drain(30);

      // Mid-word reset after slice 1 of A, then B must start fresh.
      src_q.push_back(mkv(64'h7777_6666_5555_4444, 16'h7777, 16'h6666, 16'h5555, 16'h4444));
      cycle();
      cycle();
      cycle();
      @(posedge sys_clk);
      #1 pipe_stb_i = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("mid_rst_stb_o", pipe_stb_o, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ack_o", pipe_ack_o, 1'b1);
      chk("mid_rst_dat_o", dat_o, 16'h0000);
      exp_q.delete();
      src_q.delete();
      @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      src_q.push_back(mkv(64'h9B9B_9A9A_9999_9898, 16'h9B9B, 16'h9A9A, 16'h9999, 16'h9898));
      drain(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
